// File: rtl/wrr_pri_sched.sv
// Weighted round-robin grant scheduler for PRI_NUM priority queues on one port.
// Define WRR_STRICT_TOP_EN to serve queue PRI_NUM-1 with strict priority.
module wrr_pri_sched #(
  parameter int PRI_NUM        = 8,
  parameter int WRR_WEIGHT_NUM = 8,
  parameter int PORT_ID        = 0,
  localparam int WW = $clog2(WRR_WEIGHT_NUM) + 1,
  localparam int IW = $clog2(PRI_NUM)
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [PRI_NUM*WW-1:0] iWrrWeightPld,
  input  logic [3:0]            iWrrWeightIdx,
  input  logic                  iWrrWeightLoad,
  input  logic [PRI_NUM-1:0]    iReqVld,
  output logic                  oGntVld,
  output logic [IW-1:0]         oGntIdx,
  input  logic                  iGntRdy,
  input  logic                  iPktDone,
  output logic                  oBusy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_t;

  localparam logic [WW-1:0] WMAX = WW'(WRR_WEIGHT_NUM);
  localparam logic [IW-1:0] TOP  = IW'(PRI_NUM - 1);

`ifdef WRR_STRICT_TOP_EN
  localparam logic [PRI_NUM-1:0] WRR_MASK =
    {1'b0, {(PRI_NUM-1){1'b1}}};
`else
  localparam logic [PRI_NUM-1:0] WRR_MASK = '1;
`endif

  state_t state_q, state_d;

  logic          gnt_vld_q, gnt_vld_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [WW-1:0] weight_q [PRI_NUM];
  logic [WW-1:0] shadow_q [PRI_NUM];
  logic [WW-1:0] credit_q [PRI_NUM];
  logic [WW-1:0] shadow_nxt [PRI_NUM];

  logic               load_hit;
  logic               wt_chg;
  logic [PRI_NUM-1:0] elig;
  logic [PRI_NUM-1:0] wrr_req;
  logic               any_elig;
  logic               any_wrr_req;
  logic               top_hit;
  logic               strict_gnt;
  logic [IW-1:0]      sel;
  logic               found;
  logic               dec_en;
  logic               reload_en;

  function automatic logic [IW-1:0] rot_idx(
    input logic [IW-1:0] base,
    input int            ofs
  );
    int s;
    s = int'(base) + ofs;
    return IW'(s % PRI_NUM);
  endfunction

  assign load_hit = iWrrWeightLoad &&
                    (iWrrWeightIdx == 4'(PORT_ID));

  // Shadow as it will be after this cycle; a load coinciding
  // with a round boundary feeds straight into the reload.
  always_comb begin
    wt_chg = 1'b0;
    for (int k = 0; k < PRI_NUM; k++) begin
      shadow_nxt[k] = shadow_q[k];
      if (load_hit) begin
        if (iWrrWeightPld[k*WW +: WW] > WMAX)
          shadow_nxt[k] = WMAX;
        else
          shadow_nxt[k] = iWrrWeightPld[k*WW +: WW];
      end
      wt_chg = wt_chg | (shadow_nxt[k] != weight_q[k]);
    end
  end

  always_comb begin
    elig    = '0;
    wrr_req = '0;
    for (int k = 0; k < PRI_NUM; k++) begin
      wrr_req[k] = iReqVld[k] && (weight_q[k] != '0);
      elig[k]    = wrr_req[k] && (credit_q[k] != '0);
    end
    wrr_req     = wrr_req & WRR_MASK;
    elig        = elig & WRR_MASK;
    any_elig    = |elig;
    any_wrr_req = |wrr_req;
  end

  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < PRI_NUM; i++) begin
      if (!found && elig[rot_idx(ptr_q, i)]) begin
        found = 1'b1;
        sel   = rot_idx(ptr_q, i);
      end
    end
  end

`ifdef WRR_STRICT_TOP_EN
  assign top_hit    = iReqVld[PRI_NUM-1];
  assign strict_gnt = (gnt_idx_q == TOP);
`else
  assign top_hit    = 1'b0;
  assign strict_gnt = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_vld_d = gnt_vld_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    dec_en    = 1'b0;
    reload_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (top_hit) begin
          state_d   = GRANT;
          gnt_vld_d = 1'b1;
          gnt_idx_d = TOP;
        end else if (any_elig) begin
          state_d   = GRANT;
          gnt_vld_d = 1'b1;
          gnt_idx_d = sel;
        end else if (any_wrr_req) begin
          reload_en = 1'b1;
        end else if (iReqVld == '0 && wt_chg) begin
          reload_en = 1'b1;
        end
      end
      GRANT: begin
        if (iGntRdy) begin
          state_d   = XFER;
          gnt_vld_d = 1'b0;
          if (!strict_gnt) begin
            dec_en = 1'b1;
            ptr_d  = gnt_idx_q;
          end
        end
      end
      XFER: begin
        if (iPktDone)
          state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      for (int k = 0; k < PRI_NUM; k++) begin
        weight_q[k] <= WMAX;
        shadow_q[k] <= WMAX;
        credit_q[k] <= WMAX;
      end
    end else begin
      state_q   <= state_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      for (int k = 0; k < PRI_NUM; k++)
        shadow_q[k] <= shadow_nxt[k];
      if (reload_en) begin
        for (int k = 0; k < PRI_NUM; k++) begin
          weight_q[k] <= shadow_nxt[k];
          credit_q[k] <= shadow_nxt[k];
        end
      end else if (dec_en) begin
        credit_q[gnt_idx_q] <= credit_q[gnt_idx_q] - WW'(1);
      end
    end
  end

  assign oGntVld = gnt_vld_q;
  assign oGntIdx = gnt_idx_q;
  assign oBusy   = (state_q != IDLE);

endmodule

// File: tb/tb_wrr_pri_sched.sv
// Directed self-checking bench for wrr_pri_sched (default parameters).
// Strict top-queue checks follow WRR_STRICT_TOP_EN.
module tb_wrr_pri_sched;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic [31:0] iWrrWeightPld;
  logic [3:0]  iWrrWeightIdx;
  logic        iWrrWeightLoad;
  logic [7:0]  iReqVld;
  logic        oGntVld;
  logic [2:0]  oGntIdx;
  logic        iGntRdy;
  logic        iPktDone;
  logic        oBusy;

  int n_cmp = 0;
  int n_bad = 0;

  wrr_pri_sched dut (
    .iClk           (iClk),
    .iRst_n         (iRst_n),
    .iWrrWeightPld  (iWrrWeightPld),
    .iWrrWeightIdx  (iWrrWeightIdx),
    .iWrrWeightLoad (iWrrWeightLoad),
    .iReqVld        (iReqVld),
    .oGntVld        (oGntVld),
    .oGntIdx        (oGntIdx),
    .iGntRdy        (iGntRdy),
    .iPktDone       (iPktDone),
    .oBusy          (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic do_reset();
    iRst_n         = 1'b0;
    iWrrWeightPld  = '0;
    iWrrWeightIdx  = '0;
    iWrrWeightLoad = 1'b0;
    iReqVld        = '0;
    iGntRdy        = 1'b0;
    iPktDone       = 1'b0;
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  // Wait for a grant, let it handshake (iGntRdy=1), EOP 3 cycles later.
  task automatic run_pkt(output logic [2:0] idx, output bit ok);
    ok  = 1'b0;
    idx = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iClk);
      if (oGntVld === 1'b1) begin
        ok  = 1'b1;
        idx = oGntIdx;
        break;
      end
    end
    if (!ok) return;
    repeat (3) @(negedge iClk);
    iPktDone = 1'b1;
    @(negedge iClk);
    iPktDone = 1'b0;
  endtask

  task automatic chk_pkt(string nm, int exp_idx);
    logic [2:0] g;
    bit ok;
    run_pkt(g, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: no grant seen, expected queue %0d", nm, exp_idx);
    end else if (g !== 3'(exp_idx)) begin
      n_bad++;
      $display("FAIL %s: got queue %0d expected %0d", nm, g, exp_idx);
    end
  endtask

  task automatic load_w(logic [31:0] pld, logic [3:0] idx);
    @(negedge iClk);
    iWrrWeightPld  = pld;
    iWrrWeightIdx  = idx;
    iWrrWeightLoad = 1'b1;
    @(negedge iClk);
    iWrrWeightLoad = 1'b0;
    iWrrWeightPld  = '0;
  endtask

  task automatic test_reset();
    iRst_n  = 1'b0;
    iReqVld = '0;
    iGntRdy = 1'b0;
    iPktDone = 1'b0;
    iWrrWeightLoad = 1'b0;
    iWrrWeightPld = '0;
    iWrrWeightIdx = '0;
    @(negedge iClk);
    n_cmp++;
    if (oGntVld !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_vld: got %b expected 0", oGntVld);
    end
    n_cmp++;
    if (oGntIdx !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_idx: got %0d expected 0", oGntIdx);
    end
    n_cmp++;
    if (oBusy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy: got %b expected 0", oBusy);
    end
    iRst_n = 1'b1;
  endtask

  task automatic test_default_wrr();
    do_reset();
    iGntRdy = 1'b1;
    iReqVld = 8'hFF;
    for (int p = 0; p < 64; p++)
      chk_pkt($sformatf("dflt_pkt%0d", p), p / 8);
  endtask

  task automatic test_weights();
    int exp7 [7] = '{0, 1, 1, 7, 7, 7, 7};
    int cnt [8];
    logic [2:0] g;
    bit ok;
    do_reset();
    iGntRdy = 1'b1;
    load_w(32'h4000_0021, 4'd0);
    iReqVld = 8'hFF;
    for (int p = 0; p < 7; p++)
      chk_pkt($sformatf("wt_order%0d", p), exp7[p]);
    for (int k = 0; k < 8; k++) cnt[k] = 0;
    for (int p = 0; p < 7; p++) begin
      run_pkt(g, ok);
      if (ok) cnt[g]++;
    end
    n_cmp++;
    if (cnt[0] != 1 || cnt[1] != 2 || cnt[7] != 4) begin
      n_bad++;
      $display("FAIL wt_round2: got q0=%0d q1=%0d q7=%0d expected 1 2 4",
               cnt[0], cnt[1], cnt[7]);
    end
  endtask

  task automatic test_wrong_port();
    do_reset();
    iGntRdy = 1'b1;
    load_w(32'h4000_0021, 4'd5);
    iReqVld = 8'hFF;
    for (int p = 0; p < 16; p++)
      chk_pkt($sformatf("wrongport_pkt%0d", p), p / 8);
  endtask

  task automatic test_clamp();
    do_reset();
    iGntRdy = 1'b1;
    load_w(32'h0000_001F, 4'd0);
    iReqVld = 8'h03;
    for (int p = 0; p < 9; p++)
      chk_pkt($sformatf("clamp_pkt%0d", p), (p < 8) ? 0 : 1);
  endtask

  task automatic test_hold();
    int bad_cyc;
    do_reset();
    iGntRdy = 1'b0;
    iReqVld = 8'h01;
    for (int i = 0; i < 20 && oGntVld !== 1'b1; i++)
      @(negedge iClk);
    bad_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (oGntVld !== 1'b1 || oGntIdx !== 3'd0 || oBusy !== 1'b1)
        bad_cyc++;
      @(negedge iClk);
    end
    n_cmp++;
    if (bad_cyc != 0) begin
      n_bad++;
      $display("FAIL hold_stable: got %0d unstable cycles expected 0",
               bad_cyc);
    end
    iGntRdy = 1'b1;
    @(negedge iClk);
    n_cmp++;
    if (oGntVld !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_accept: got vld %b expected 0", oGntVld);
    end
    repeat (2) @(negedge iClk);
    iPktDone = 1'b1;
    @(negedge iClk);
    iPktDone = 1'b0;
    iReqVld = 8'hFF;
    for (int p = 0; p < 8; p++)
      chk_pkt($sformatf("hold_credit%0d", p), (p < 7) ? 0 : 1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    iGntRdy = 1'b0;
    iReqVld = 8'h01;
    for (int i = 0; i < 20 && oGntVld !== 1'b1; i++)
      @(negedge iClk);
    iPktDone = 1'b1;
    @(negedge iClk);
    iPktDone = 1'b0;
    n_cmp++;
    if (oGntVld !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_done_in_grant: got vld %b expected 1", oGntVld);
    end
    iGntRdy = 1'b1;
    @(negedge iClk);
    n_cmp++;
    if (oGntVld !== 1'b0 || oBusy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_xfer: got vld %b busy %b expected 0 1",
               oGntVld, oBusy);
    end
    iPktDone = 1'b1;
    @(negedge iClk);
    iPktDone = 1'b0;
    n_cmp++;
    if (oGntVld !== 1'b0 || oBusy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: got vld %b busy %b expected 0 0",
               oGntVld, oBusy);
    end
    @(negedge iClk);
    n_cmp++;
    if (oGntVld !== 1'b1 || oGntIdx !== 3'd0) begin
      n_bad++;
      $display("FAIL b2b_regrant: got vld %b idx %0d expected 1 0",
               oGntVld, oGntIdx);
    end
  endtask

  task automatic test_reset_mid();
    int early;
    do_reset();
    iGntRdy = 1'b1;
    iReqVld = 8'hFF;
    chk_pkt("rstmid_pre0", 0);
    chk_pkt("rstmid_pre1", 0);
    for (int i = 0; i < 20 && oGntVld !== 1'b1; i++)
      @(negedge iClk);
    @(negedge iClk);
    iRst_n  = 1'b0;
    iReqVld = '0;
    #1;
    n_cmp++;
    if (oGntVld !== 1'b0 || oBusy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_abort: got vld %b busy %b expected 0 0",
               oGntVld, oBusy);
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      if (oGntVld !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_bad++;
      $display("FAIL rstmid_nogrant: got %0d grant cycles expected 0",
               early);
    end
    iReqVld = 8'hFF;
    for (int p = 0; p < 9; p++)
      chk_pkt($sformatf("rstmid_credit%0d", p), (p < 8) ? 0 : 1);
  endtask

  task automatic test_top_queue();
    do_reset();
    iGntRdy = 1'b1;
    iReqVld = 8'h81;
`ifdef WRR_STRICT_TOP_EN
    for (int p = 0; p < 10; p++)
      chk_pkt($sformatf("strict_top%0d", p), 7);
    iReqVld = 8'h01;
    chk_pkt("strict_low", 0);
`else
    for (int p = 0; p < 9; p++)
      chk_pkt($sformatf("wrr_top%0d", p), (p < 8) ? 0 : 7);
`endif
  endtask

  initial begin
    test_reset();
    test_default_wrr();
    test_weights();
    test_wrong_port();
    test_clamp();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_top_queue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
